// File: rtl/datamem_arbiter_if.sv
// rtl/datamem_arbiter_if.sv - requester and data-memory signals of datamem_arbiter
interface datamem_arbiter_if #(
   parameter int AW = 6,
   parameter int DW = 32
);
   logic          Req0;
   logic          We0;
   logic [AW-1:0] Addr0;
   logic [DW-1:0] WData0;
   logic          Req1;
   logic          We1;
   logic [AW-1:0] Addr1;
   logic [DW-1:0] WData1;
   logic          Gnt0;
   logic          Gnt1;
   logic          RValid0;
   logic          RValid1;
   logic [DW-1:0] RData0;
   logic [DW-1:0] RData1;
   logic          MemoryRead;
   logic          MemoryWrite;
   logic [AW-1:0] MemAddress;
   logic [DW-1:0] MemWriteData;
   logic [DW-1:0] MemReadData;

   // arbiter side
   modport slave (
      input  Req0, We0, Addr0, WData0, Req1, We1, Addr1, WData1, MemReadData,
      output Gnt0, Gnt1, RValid0, RValid1, RData0, RData1,
             MemoryRead, MemoryWrite, MemAddress, MemWriteData
   );

   // requester / memory environment side
   modport master (
      output Req0, We0, Addr0, WData0, Req1, We1, Addr1, WData1, MemReadData,
      input  Gnt0, Gnt1, RValid0, RValid1, RData0, RData1,
             MemoryRead, MemoryWrite, MemAddress, MemWriteData
   );
endinterface

// File: rtl/datamem_arbiter.sv
// rtl/datamem_arbiter.sv - two-port data-memory arbiter, fixed priority or round-robin (DATAMEM_ARB_RR_EN)
module datamem_arbiter #(
   parameter int AW = 6,
   parameter int DW = 32
) (
   input  logic Clock,
   input  logic Reset,
   datamem_arbiter_if.slave bus
);
   logic       LastGnt;
   logic [1:0] RdTag;
   logic       gnt0;
   logic       gnt1;

   // Grant is purely combinational so the access happens in the request cycle.
   always_comb begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
      if (!Reset) begin
         if (bus.Req0 && bus.Req1) begin
`ifdef DATAMEM_ARB_RR_EN
            gnt0 = LastGnt;
            gnt1 = ~LastGnt;
`else
            gnt0 = 1'b1;
`endif
         end else begin
            gnt0 = bus.Req0;
            gnt1 = bus.Req1;
         end
      end
   end

`ifndef DATAMEM_ARB_RR_EN
   logic unused_lastgnt;
   assign unused_lastgnt = LastGnt;
`endif

   always_ff @(posedge Clock) begin
      if (Reset) begin
         RdTag   <= 2'b00;
         LastGnt <= 1'b1;
      end else begin
         RdTag <= {gnt1 & ~bus.We1, gnt0 & ~bus.We0};
         if (gnt0)
            LastGnt <= 1'b0;
         else if (gnt1)
            LastGnt <= 1'b1;
      end
   end

   always_comb begin
      bus.Gnt0         = gnt0;
      bus.Gnt1         = gnt1;
      bus.MemoryRead   = 1'b0;
      bus.MemoryWrite  = 1'b0;
      bus.MemAddress   = '0;
      bus.MemWriteData = '0;
      if (gnt0) begin
         bus.MemoryRead   = ~bus.We0;
         bus.MemoryWrite  = bus.We0;
         bus.MemAddress   = bus.Addr0;
         bus.MemWriteData = bus.WData0;
      end else if (gnt1) begin
         bus.MemoryRead   = ~bus.We1;
         bus.MemoryWrite  = bus.We1;
         bus.MemAddress   = bus.Addr1;
         bus.MemWriteData = bus.WData1;
      end
   end

   // Masking with Reset drops a read granted just before reset is applied.
   always_comb begin
      bus.RValid0 = RdTag[0] & ~Reset;
      bus.RValid1 = RdTag[1] & ~Reset;
      bus.RData0  = bus.RValid0 ? bus.MemReadData : '0;
      bus.RData1  = bus.RValid1 ? bus.MemReadData : '0;
   end
endmodule

// File: tb/tb_datamem_arbiter.sv
// tb/tb_datamem_arbiter.sv - self-checking bench for datamem_arbiter
module tb_datamem_arbiter;
`ifdef DATAMEM_ARB_RR_EN
   localparam bit RR = 1'b1;
`else
   localparam bit RR = 1'b0;
`endif

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   datamem_arbiter_if #(.AW(6), .DW(32)) bus ();
   datamem_arbiter #(.AW(6), .DW(32)) dut (.Clock(Clock), .Reset(Reset), .bus(bus));

   always #5 Clock = ~Clock;

   logic [31:0] mem [64] = '{default: 32'h0};
   always @(posedge Clock) begin
      if (bus.MemoryWrite) mem[bus.MemAddress] <= bus.MemWriteData;
      if (bus.MemoryRead)  bus.MemReadData <= mem[bus.MemAddress];
   end

   typedef struct {
      bit r0; bit w0; bit [5:0] a0; bit [31:0] d0;
      bit r1; bit w1; bit [5:0] a1; bit [31:0] d1;
      bit [1:0] gfp; bit [1:0] grr;
   } vec_t;

   typedef struct { bit port; logic [31:0] data; } rd_t;

   rd_t         sb[$];
   logic [31:0] refmem [64] = '{default: 32'h0};
   vec_t        vecs[16];

   function automatic vec_t mk(bit r0, bit w0, bit [5:0] a0, bit [31:0] d0,
                               bit r1, bit w1, bit [5:0] a1, bit [31:0] d1,
                               bit [1:0] gfp, bit [1:0] grr);
      vec_t v;
      v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
      v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
      v.gfp = gfp; v.grr = grr;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic check_return();
      rd_t e;
      bit [1:0] v;
      logic [31:0] d;
      v = 2'b00;
      d = 32'h0;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         v = e.port ? 2'b10 : 2'b01;
         d = e.data;
      end
      chk("rvalid0", {31'b0, bus.RValid0}, {31'b0, v[0]});
      chk("rvalid1", {31'b0, bus.RValid1}, {31'b0, v[1]});
      chk("rdata0", bus.RData0, v[0] ? d : 32'h0);
      chk("rdata1", bus.RData1, v[1] ? d : 32'h0);
   endtask

   task automatic apply(input vec_t v);
      bit [1:0]    g;
      bit          ew;
      bit [5:0]    ea;
      bit [31:0]   ed;
      rd_t         e;
      bus.Req0 = v.r0; bus.We0 = v.w0; bus.Addr0 = v.a0; bus.WData0 = v.d0;
      bus.Req1 = v.r1; bus.We1 = v.w1; bus.Addr1 = v.a1; bus.WData1 = v.d1;
      @(negedge Clock);
      g = RR ? v.grr : v.gfp;
      ew = 1'b0; ea = 6'd0; ed = 32'h0;
      if (g[0]) begin ew = v.w0; ea = v.a0; ed = v.d0; end
      else if (g[1]) begin ew = v.w1; ea = v.a1; ed = v.d1; end
      chk("gnt0", {31'b0, bus.Gnt0}, {31'b0, g[0]});
      chk("gnt1", {31'b0, bus.Gnt1}, {31'b0, g[1]});
      chk("gnt_onehot", {31'b0, bus.Gnt0 & bus.Gnt1}, 32'h0);
      chk("mem_write", {31'b0, bus.MemoryWrite}, {31'b0, (g != 2'b00) & ew});
      chk("mem_read", {31'b0, bus.MemoryRead}, {31'b0, (g != 2'b00) & ~ew});
      chk("mem_addr", {26'b0, bus.MemAddress}, {26'b0, ea});
      chk("mem_wdata", bus.MemWriteData, ed);
      check_return();
      if (g != 2'b00) begin
         if (ew) refmem[ea] = ed;
         else begin
            e.port = g[1];
            e.data = refmem[ea];
            sb.push_back(e);
         end
      end
      @(posedge Clock); #1;
   endtask

   initial begin
      vecs[0]  = mk(1,1,5,32'hDEADBEEF, 0,0,0,0,          2'b01, 2'b01);
      vecs[1]  = mk(1,0,5,0,            0,0,0,0,          2'b01, 2'b01);
      vecs[2]  = mk(1,1,1,32'h11,       0,0,0,0,          2'b01, 2'b01);
      vecs[3]  = mk(0,0,0,0,            1,1,2,32'h22,     2'b10, 2'b10);
      vecs[4]  = mk(1,0,1,0,            1,0,2,0,          2'b01, 2'b01);
      vecs[5]  = mk(1,0,1,0,            1,0,2,0,          2'b01, 2'b10);
      vecs[6]  = mk(1,0,1,0,            1,0,2,0,          2'b01, 2'b01);
      vecs[7]  = mk(1,0,1,0,            1,0,2,0,          2'b01, 2'b10);
      vecs[8]  = mk(0,0,0,0,            0,0,0,0,          2'b00, 2'b00);
      vecs[9]  = mk(0,0,0,0,            0,0,0,0,          2'b00, 2'b00);
      vecs[10] = mk(0,0,0,0,            0,0,0,0,          2'b00, 2'b00);
      vecs[11] = mk(1,1,63,32'hA5A5A5A5, 1,0,63,0,        2'b01, 2'b01);
      vecs[12] = mk(0,0,0,0,            1,0,63,0,         2'b10, 2'b10);
      vecs[13] = mk(0,0,0,0,            1,1,10,32'h12345678, 2'b10, 2'b10);
      vecs[14] = mk(0,0,0,0,            1,0,10,0,         2'b10, 2'b10);
      vecs[15] = mk(0,0,0,0,            0,0,0,0,          2'b00, 2'b00);

      // Reset held with both ports requesting: nothing may be granted.
      bus.Req0 = 1; bus.We0 = 0; bus.Addr0 = 6'd3; bus.WData0 = 32'h0;
      bus.Req1 = 1; bus.We1 = 1; bus.Addr1 = 6'd4; bus.WData1 = 32'h55;
      repeat (2) begin
         @(negedge Clock);
         chk("rst_gnt0", {31'b0, bus.Gnt0}, 32'h0);
         chk("rst_gnt1", {31'b0, bus.Gnt1}, 32'h0);
         chk("rst_mem_en", {30'b0, bus.MemoryRead, bus.MemoryWrite}, 32'h0);
         chk("rst_mem_addr", {26'b0, bus.MemAddress}, 32'h0);
         chk("rst_mem_wdata", bus.MemWriteData, 32'h0);
         check_return();
         @(posedge Clock); #1;
      end
      Reset = 0;

      for (int i = 0; i < 16; i++) apply(vecs[i]);

      // Port 1 read followed immediately by reset: the return must be dropped.
      apply(mk(0,0,0,0, 1,0,2,0, 2'b10, 2'b10));
      sb.delete();
      Reset = 1;
      bus.Req0 = 1; bus.Req1 = 1;
      @(negedge Clock);
      chk("midrst_gnt", {30'b0, bus.Gnt1, bus.Gnt0}, 32'h0);
      chk("midrst_mem_en", {30'b0, bus.MemoryRead, bus.MemoryWrite}, 32'h0);
      chk("midrst_rvalid1", {31'b0, bus.RValid1}, 32'h0);
      chk("midrst_rdata1", bus.RData1, 32'h0);
      @(posedge Clock); #1;
      Reset = 0;
      apply(mk(0,0,0,0, 0,0,0,0, 2'b00, 2'b00));
      // First tie after reset goes to port 0 in either mode.
      apply(mk(1,0,1,0, 1,0,2,0, 2'b01, 2'b01));
      apply(mk(0,0,0,0, 0,0,0,0, 2'b00, 2'b00));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
